// File: rtl/tx_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_filter_pkg
//  Description : Shared widths, helpers and sample/coefficient types for the
//                multiplierless symmetric TX pulse-shaping FIR.
//  Build option: TX_FILTER_SAT_EN (clamp output instead of wrapping)
//  Revision    : 1.0  initial release
// ============================================================================
package tx_filter_pkg;

    localparam int DEF_DW       = 18;
    localparam int DEF_CW       = 18;
    localparam int DEF_SYM_BITS = 4;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    // Accumulator width large enough that summing HALF full-width products
    // can never overflow.
    function automatic int acc_w(input int cw, input int sym_bits, input int half);
        return cw + sym_bits + 1 + clog2(half);
    endfunction

    typedef logic signed [DEF_DW-1:0] sample_t;
    typedef logic signed [DEF_CW-1:0] coef_t;

endpackage
`default_nettype wire

// File: rtl/tx_filt_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module      : tx_filt_shift_add_mult
//  Description : Combinational coefficient x small signed integer product,
//                formed as a sum of shifted coefficients (no multiplier).
//  Build option: TX_FILTER_SAT_EN (not used in this block)
//  Revision    : 1.0  initial release
// ============================================================================
module tx_filt_shift_add_mult
    import tx_filter_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int SYM_BITS = DEF_SYM_BITS
) (
    input  logic signed [CW-1:0]         coef,
    input  logic signed [SYM_BITS:0]     mult,
    output logic signed [CW+SYM_BITS:0]  prod
);

    localparam int PW = CW + SYM_BITS + 1;

    logic signed [PW-1:0] coef_ext;

    assign coef_ext = {{(PW-CW){coef[CW-1]}}, coef};

    // Two's-complement weights: low bits add coef<<b, the sign bit subtracts.
    always_comb begin
        prod = '0;
        for (int b = 0; b < SYM_BITS; b++) begin
            if (mult[b]) prod = prod + (coef_ext <<< b);
        end
        if (mult[SYM_BITS]) prod = prod - (coef_ext <<< SYM_BITS);
    end

endmodule
`default_nettype wire

// File: rtl/tx_filter_lut_param.sv
`default_nettype none
// ============================================================================
//  Module      : tx_filter_lut_param
//  Description : Parametrised multiplierless symmetric TX pulse-shaping FIR.
//                Symbol MSBs -> delay line -> pair sums (S1) -> shift-add
//                products (S2) -> accumulate, scale, narrow (S3).
//  Build option: TX_FILTER_SAT_EN defined  -> output clamps to DW range
//                TX_FILTER_SAT_EN undefined -> output wraps (two's complement)
//  Revision    : 1.0  initial release
// ============================================================================
module tx_filter_lut_param
    import tx_filter_pkg::*;
#(
    parameter int NTAPS    = 21,
    parameter int DW       = DEF_DW,
    parameter int CW       = DEF_CW,
    parameter int SYM_BITS = DEF_SYM_BITS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic signed [DW-1:0]                x_in,
    input  logic                                x_valid,
    input  logic                                coef_we,
    input  logic [clog2((NTAPS+1)/2)-1:0]       coef_addr,
    input  logic signed [CW-1:0]                coef_data,
    output logic signed [DW-1:0]                y,
    output logic                                y_valid
);

    localparam int HALF  = (NTAPS + 1) / 2;
    localparam int AW    = clog2(HALF);
    localparam int SW    = SYM_BITS + 1;
    localparam int PW    = CW + SYM_BITS + 1;
    localparam int ACC_W = acc_w(CW, SYM_BITS, HALF);
    localparam int SHIFT = SYM_BITS - 1;

    logic signed [SYM_BITS-1:0] d      [NTAPS];
    logic signed [SW-1:0]       p      [HALF];
    logic signed [CW-1:0]       coef   [HALF];
    logic signed [PW-1:0]       prod_c [HALF];
    logic signed [PW-1:0]       prod_r [HALF];
    logic [2:0]                 vld;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    r;
    logic signed [DW-1:0]       y_next;

    // Only the symbol MSBs of each sample feed the filter.
    logic unused_x_lsbs;
    assign unused_x_lsbs = ^x_in[DW-SYM_BITS-1:0];

    // Symbol delay line, advancing only on accepted samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NTAPS; i++) d[i] <= '0;
        end else if (x_valid) begin
            d[0] <= x_in[DW-1 -: SYM_BITS];
            for (int i = 1; i < NTAPS; i++) d[i] <= d[i-1];
        end
    end

    // S1: fold the symmetric taps into pair sums; centre tap passes alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < HALF; k++) p[k] <= '0;
        end else begin
            for (int k = 0; k < HALF-1; k++) begin
                p[k] <= {d[k][SYM_BITS-1], d[k]}
                      + {d[NTAPS-1-k][SYM_BITS-1], d[NTAPS-1-k]};
            end
            p[HALF-1] <= {d[HALF-1][SYM_BITS-1], d[HALF-1]};
        end
    end

    // Coefficient bank; addresses beyond the centre tap are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < HALF; k++) coef[k] <= '0;
        end else if (coef_we) begin
            for (int k = 0; k < HALF; k++) begin
                if (coef_addr == AW'(k)) coef[k] <= coef_data;
            end
        end
    end

    for (genvar k = 0; k < HALF; k++) begin : g_mult
        tx_filt_shift_add_mult #(
            .CW       (CW),
            .SYM_BITS (SYM_BITS)
        ) u_mult (
            .coef (coef[k]),
            .mult (p[k]),
            .prod (prod_c[k])
        );
    end

    // S2: register the full-width products.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < HALF; k++) prod_r[k] <= '0;
        end else begin
            for (int k = 0; k < HALF; k++) prod_r[k] <= prod_c[k];
        end
    end

    // S3: sign-extended sum of all products.
    always_comb begin
        acc = '0;
        for (int k = 0; k < HALF; k++) begin
            acc = acc + {{(ACC_W-PW){prod_r[k][PW-1]}}, prod_r[k]};
        end
    end

    // Floor scaling back to the 1s17 output format.
    assign r = acc >>> SHIFT;

`ifdef TX_FILTER_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    // Clamp the scaled sum into the output range.
    always_comb begin
        if (r > Y_MAX) begin
            y_next = {1'b0, {(DW-1){1'b1}}};
        end else if (r < Y_MIN) begin
            y_next = {1'b1, {(DW-1){1'b0}}};
        end else begin
            y_next = r[DW-1:0];
        end
    end
`else
    // Plain truncation: out-of-range sums wrap.
    assign y_next = r[DW-1:0];

    logic unused_r_msbs;
    assign unused_r_msbs = ^r[ACC_W-1:DW];
`endif

    // Valid pipe tracks d/p/prod; y only updates when a real sample lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            vld     <= {vld[1:0], x_valid};
            y_valid <= vld[2];
            if (vld[2]) y <= y_next;
        end
    end

endmodule
`default_nettype wire
